// File: rtl/dut_vec_sequencer_pkg.sv
// Shared types for the vector sequencer: FSM state encoding, unpacker mode codes
// and a small constant helper used for counter sizing.
package dut_vec_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_STEP   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_UNLOAD = 3'd5,
    ST_FIN    = 3'd6
  } seq_state_e;

  localparam logic IN_MODE_WRITE = 1'b0;
  localparam logic IN_MODE_CLEAR = 1'b1;

  function automatic int seq_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dut_vec_sequencer_wait_timer.sv
// seq_wait_timer: counts consecutive enabled cycles and flags the LIMIT-th one.
// Only built when DUT_WAIT_TIMEOUT_EN is defined.
`ifdef DUT_WAIT_TIMEOUT_EN
module seq_wait_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_expired
);

  localparam int TW = $clog2(LIMIT + 1);

  logic [TW-1:0] r_cnt;

  // Cycle counter, restarts whenever the enable drops; saturates at LIMIT.
  always_ff @(posedge clk) begin
    if (reset || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt != TW'(LIMIT)) begin
      r_cnt <= r_cnt + TW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = i_en && (r_cnt == TW'(LIMIT - 1));

endmodule
`endif

// File: rtl/dut_vec_sequencer.sv
// dut_vec_sequencer: loads an input vector from a stream, steps the DUT, and streams
// the output vector back. Optional WAIT timeout enabled by DUT_WAIT_TIMEOUT_EN.
module dut_vec_sequencer
  import dut_vec_sequencer_pkg::*;
#(
  parameter int IN_WORDS   = 8,
  parameter int OUT_WORDS  = 8,
  parameter int WAIT_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        clear_in,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  input  logic [31:0] s_word,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] m_word,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] in_addr,
  output logic        in_en,
  output logic        in_mode,
  output logic [31:0] in_word,
  output logic [31:0] out_addr,
  output logic        out_en,
  output logic        out_mode,
  input  logic [31:0] out_word,
  output logic        dut_step,
  input  logic        dut_done
);

  localparam int            CW       = $clog2(seq_max(IN_WORDS, OUT_WORDS)) + 1;
  localparam logic [CW-1:0] LAST_IN  = CW'(IN_WORDS - 1);
  localparam logic [CW-1:0] LAST_OUT = CW'(OUT_WORDS - 1);

  seq_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic          w_in_wait;

  assign w_in_wait = (r_state == ST_WAIT);

`ifdef DUT_WAIT_TIMEOUT_EN
  logic w_expired;
  logic r_err;

  seq_wait_timer #(.LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .i_en      (w_in_wait),
    .o_expired (w_expired)
  );

  // Sticky timeout flag; a newly accepted start clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_err <= 1'b0;
    end else if (w_in_wait && !dut_done && w_expired) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign err_timeout = r_err;
`else
  logic w_unused_limit;
  assign w_unused_limit = (WAIT_LIMIT > 0);
  assign err_timeout    = 1'b0;
`endif

  // Transaction FSM and shared word counter; STEP always advances, so a dut_done
  // coinciding with dut_step is never seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_state <= clear_in ? ST_CLEAR : ST_LOAD;
          end
        end
        ST_CLEAR: r_state <= ST_LOAD;
        ST_LOAD: begin
          if (s_valid) begin
            if (r_cnt == LAST_IN) begin
              r_cnt   <= '0;
              r_state <= ST_STEP;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_STEP: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (dut_done) begin
            r_state <= ST_UNLOAD;
`ifdef DUT_WAIT_TIMEOUT_EN
          end else if (w_expired) begin
            r_state <= ST_FIN;
`endif
          end
        end
        ST_UNLOAD: begin
          if (m_ready) begin
            if (r_cnt == LAST_OUT) begin
              r_cnt   <= '0;
              r_state <= ST_FIN;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_FIN: r_state <= ST_IDLE;
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign out_mode = 1'b0;

  // Output decode from the registered state; only the load write path and the
  // unload word pass straight through.
  always_comb begin
    busy     = (r_state != ST_IDLE);
    done     = (r_state == ST_FIN);
    dut_step = (r_state == ST_STEP);
    s_ready  = (r_state == ST_LOAD);
    in_en    = 1'b0;
    in_mode  = IN_MODE_WRITE;
    in_addr  = 32'd0;
    in_word  = 32'd0;
    out_en   = 1'b0;
    out_addr = 32'd0;
    m_valid  = 1'b0;
    m_word   = 32'd0;
    case (r_state)
      ST_CLEAR: begin
        in_en   = 1'b1;
        in_mode = IN_MODE_CLEAR;
      end
      ST_LOAD: begin
        in_en   = s_valid;
        in_addr = 32'(r_cnt);
        in_word = s_valid ? s_word : 32'd0;
      end
      ST_UNLOAD: begin
        out_en   = 1'b1;
        out_addr = 32'(r_cnt);
        m_valid  = 1'b1;
        m_word   = out_word;
      end
      default: begin
      end
    endcase
  end

endmodule
